alu_ctrl_pipe: RTL

Registered, parametrised ALU control stage sitting on the ID/EX boundary of the 5-stage pipeline. It decodes the 11-bit LEGv8 opcode in ID into a wider ALU control word, adds flag-set and illegal-opcode indications, and registers the result into EX. It supports stall and flush. It holds EX for a parametrised number of cycles on multi-cycle MUL.

---
 rtl/alu_ctrl_pkg.sv | 60 ++++++
 rtl/alu_op_decode.sv | 64 ++++++
 rtl/alu_ctrl_pipe.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared definitions for the ID/EX ALU control stage:
//   - LEGv8 opcode constants (11-bit instruction[31:21]); opcodes that carry
//     operand bits in their low positions also get a mask (1 = bit is compared)
//   - alu_op_e: 4-bit ALU operation encodings
//   - state_e : EX register occupancy state
//   - opc_match(): masked opcode compare helper
// -----------------------------------------------------------------------------
package alu_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_PASSB = 4'b0000,
    OP_ADD   = 4'b0010,
    OP_SUB   = 4'b0011,
    OP_AND   = 4'b0100,
    OP_ORR   = 4'b0101,
    OP_EOR   = 4'b0110,
    OP_LSL   = 4'b1000,
    OP_LSR   = 4'b1001,
    OP_MUL   = 4'b1010
  } alu_op_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HOLD  = 2'd1,
    MULTI = 2'd2
  } state_e;

  // Full (exact-match) opcodes
  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_ADDS = 11'b10101011000;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_SUBS = 11'b11101011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_EOR  = 11'b11001010000;
  localparam logic [10:0] OPC_LSL  = 11'b11010011011;
  localparam logic [10:0] OPC_LSR  = 11'b11010011010;
  localparam logic [10:0] OPC_MUL  = 11'b10011011000;

  // Masked opcodes: value plus compare mask (immediate/offset bits ignored)
  localparam logic [10:0] OPC_ADDI_V = 11'b10010001000;
  localparam logic [10:0] OPC_ADDI_M = 11'b11111111110;
  localparam logic [10:0] OPC_SUBI_V = 11'b11010001000;
  localparam logic [10:0] OPC_SUBI_M = 11'b11111111110;
  localparam logic [10:0] OPC_CBZ_V  = 11'b10110100000;
  localparam logic [10:0] OPC_CBZ_M  = 11'b11111111000;
  localparam logic [10:0] OPC_BL_V   = 11'b10010100000;
  localparam logic [10:0] OPC_BL_M   = 11'b11111100000;

  function automatic logic opc_match(input logic [10:0] opc,
                                     input logic [10:0] val,
                                     input logic [10:0] mask);
    return ((opc & mask) == (val & mask));
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// -----------------------------------------------------------------------------
// alu_op_decode
// Purely combinational opcode decoder.
// Ports:
//   opcode_i    in  11  instruction[31:21]
//   alu_on_i    in  1   instruction uses the ALU
//   op_o        out 4   ALU operation (alu_op_e)
//   set_flags_o out 1   ADDS/SUBS
//   illegal_o   out 1   unsupported opcode while alu_on_i=1
//   is_mul_o    out 1   operation is MUL (multi-cycle candidate)
// With alu_on_i=0 every output is forced to 0 regardless of the opcode.
// -----------------------------------------------------------------------------
module alu_op_decode
  import alu_ctrl_pkg::*;
(
  input  logic [10:0] opcode_i,
  input  logic        alu_on_i,
  output alu_op_e     op_o,
  output logic        set_flags_o,
  output logic        illegal_o,
  output logic        is_mul_o
);

  always_comb begin
    op_o        = OP_PASSB;
    set_flags_o = 1'b0;
    illegal_o   = 1'b0;
    is_mul_o    = 1'b0;
    if (alu_on_i) begin
      if (opcode_i == OPC_ADD || opcode_i == OPC_LDUR || opcode_i == OPC_STUR ||
          opc_match(opcode_i, OPC_ADDI_V, OPC_ADDI_M)) begin
        op_o = OP_ADD;
      end else if (opcode_i == OPC_ADDS) begin
        op_o        = OP_ADD;
        set_flags_o = 1'b1;
      end else if (opcode_i == OPC_SUB ||
                   opc_match(opcode_i, OPC_SUBI_V, OPC_SUBI_M)) begin
        op_o = OP_SUB;
      end else if (opcode_i == OPC_SUBS) begin
        op_o        = OP_SUB;
        set_flags_o = 1'b1;
      end else if (opcode_i == OPC_AND) begin
        op_o = OP_AND;
      end else if (opcode_i == OPC_ORR) begin
        op_o = OP_ORR;
      end else if (opcode_i == OPC_EOR) begin
        op_o = OP_EOR;
      end else if (opcode_i == OPC_LSL) begin
        op_o = OP_LSL;
      end else if (opcode_i == OPC_LSR) begin
        op_o = OP_LSR;
      end else if (opcode_i == OPC_MUL) begin
        op_o     = OP_MUL;
        is_mul_o = 1'b1;
      end else if (opc_match(opcode_i, OPC_CBZ_V, OPC_CBZ_M) ||
                   opc_match(opcode_i, OPC_BL_V, OPC_BL_M)) begin
        op_o = OP_PASSB;
      end else begin
        illegal_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_ctrl_pipe.sv
// -----------------------------------------------------------------------------
// alu_ctrl_pipe
// Registered ALU control stage on the ID/EX boundary. Decodes the ID opcode
// and captures control word, flag-set and illegal indications into EX.
// MUL holds EX for MUL_LAT non-stalled cycles (busy on all but the last).
// Parameters:
//   CNTRL_W  ALU control width (>=4), encoding zero-extended
//   MUL_LAT  EX cycles for MUL (1..16), 1 = single-cycle
// Ports:
//   clk, rst_n (synchronous, active-low)
//   id_valid, id_opcode[10:0], id_alu_on   ID-side instruction
//   stall, flush                           pipeline control (flush wins)
//   id_ready                               accept possible this cycle
//   ex_valid, ex_alu_cntrl, ex_set_flags, ex_illegal, ex_busy   EX payload
// -----------------------------------------------------------------------------
module alu_ctrl_pipe
  import alu_ctrl_pkg::*;
#(
  parameter int CNTRL_W = 4,
  parameter int MUL_LAT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [10:0]        id_opcode,
  input  logic               id_alu_on,
  input  logic               stall,
  input  logic               flush,
  output logic               id_ready,
  output logic               ex_valid,
  output logic [CNTRL_W-1:0] ex_alu_cntrl,
  output logic               ex_set_flags,
  output logic               ex_illegal,
  output logic               ex_busy
);

  localparam int CNT_W = $clog2(MUL_LAT + 1);
  localparam bit MUL_MULTI = (MUL_LAT > 1);

  generate
    if (CNTRL_W < 4) begin : g_bad_cntrl_w
      $error("alu_ctrl_pipe: CNTRL_W must be >= 4");
    end
    if (MUL_LAT < 1 || MUL_LAT > 16) begin : g_bad_mul_lat
      $error("alu_ctrl_pipe: MUL_LAT must be in 1..16");
    end
  endgenerate

  alu_op_e dec_op;
  logic    dec_set_flags;
  logic    dec_illegal;
  logic    dec_is_mul;

  alu_op_decode u_decode (
    .opcode_i    (id_opcode),
    .alu_on_i    (id_alu_on),
    .op_o        (dec_op),
    .set_flags_o (dec_set_flags),
    .illegal_o   (dec_illegal),
    .is_mul_o    (dec_is_mul)
  );

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNTRL_W-1:0] cntrl_q, cntrl_d;
  logic               set_flags_q, set_flags_d;
  logic               illegal_q, illegal_d;
  logic               accept;

  // Ready depends only on stall and occupancy so ID can compute it early.
  assign id_ready = !stall && (state_q != MULTI);
  assign accept   = id_valid && id_ready && !flush;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cntrl_d     = cntrl_q;
    set_flags_d = set_flags_q;
    illegal_d   = illegal_q;
    if (flush) begin
      state_d     = EMPTY;
      cnt_d       = '0;
      cntrl_d     = '0;
      set_flags_d = 1'b0;
      illegal_d   = 1'b0;
    end else begin
      case (state_q)
        EMPTY, HOLD: begin
          if (accept) begin
            cntrl_d     = CNTRL_W'(dec_op);
            set_flags_d = dec_set_flags;
            illegal_d   = dec_illegal;
            if (dec_is_mul && MUL_MULTI) begin
              state_d = MULTI;
              cnt_d   = CNT_W'(MUL_LAT - 1);
            end else begin
              state_d = HOLD;
              cnt_d   = '0;
            end
          end else if (!stall) begin
            // Bubble: drain EX and keep the payload clean
            state_d     = EMPTY;
            cnt_d       = '0;
            cntrl_d     = '0;
            set_flags_d = 1'b0;
            illegal_d   = 1'b0;
          end
        end
        MULTI: begin
          if (!stall) begin
            if (cnt_q == CNT_W'(1)) begin
              state_d = HOLD;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end
        default: begin
          state_d     = EMPTY;
          cnt_d       = '0;
          cntrl_d     = '0;
          set_flags_d = 1'b0;
          illegal_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      cnt_q       <= '0;
      cntrl_q     <= '0;
      set_flags_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cntrl_q     <= cntrl_d;
      set_flags_q <= set_flags_d;
      illegal_q   <= illegal_d;
    end
  end

  assign ex_valid     = (state_q != EMPTY);
  assign ex_busy      = (state_q == MULTI);
  assign ex_alu_cntrl = cntrl_q;
  assign ex_set_flags = set_flags_q;
  assign ex_illegal   = illegal_q;

endmodule
